// File: rtl/ddr_axi_pkg.sv
// ddr_axi_pkg: shared FSM encodings and address-mapping constants for the DDR AXI responder
package ddr_axi_pkg;
  localparam int BEAT_SHIFT = 3;
  localparam int INIT_CYCLES = 4;
  localparam int INIT_W = $clog2(INIT_CYCLES);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
endpackage

// File: rtl/ddr_axi_resp_mem.sv
// ddr_axi_resp_mem: simple dual-port beat storage with byte-enabled writes and a registered read port
module ddr_axi_resp_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int BYTES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BYTES*8-1:0]    wdata,
  input  logic [BYTES-1:0]      wstrb,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [BYTES*8-1:0]    rdata
);
  logic [BYTES*8-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < BYTES; i++)
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ddr_axi_responder.sv
// ddr_axi_responder: on-chip AXI responder standing in for the DDR controller behind the frame-buffer masters
module ddr_axi_responder
  import ddr_axi_pkg::*;
#(
  parameter int MEM_ROW_WIDTH = 15,
  parameter int MEM_BANK_WIDTH = 3,
  parameter int MEM_COLUMN_WIDTH = 10,
  parameter int CTRL_ADDR_WIDTH = MEM_ROW_WIDTH + MEM_BANK_WIDTH + MEM_COLUMN_WIDTH,
  parameter int MEM_DQ_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                       ddr_clk,
  input  logic                       rst,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [3:0]                 axi_awid,
  input  logic [3:0]                 axi_awlen,
  input  logic [2:0]                 axi_awsize,
  input  logic [1:0]                 axi_awburst,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata,
  input  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic                       axi_wlast,
  output logic [3:0]                 axi_bid,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [3:0]                 axi_arid,
  input  logic [3:0]                 axi_arlen,
  input  logic [2:0]                 axi_arsize,
  input  logic [1:0]                 axi_arburst,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata,
  output logic                       axi_rvalid,
  output logic                       axi_rlast,
  output logic [3:0]                 axi_rid,
  input  logic                       axi_rready,
  output logic                       init_done
);
  localparam int IDX_W = MEM_DEPTH_LOG2;
  w_state_e          w_state;
  r_state_e          r_state;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [3:0]        w_id, w_len, w_cnt, r_id, r_len, r_cnt;
  logic [INIT_W-1:0] init_cnt;
  logic              unused;
  // size/burst are fixed to INCR and only the beat-index address bits matter
  assign unused = ^{axi_awaddr, axi_araddr, axi_awsize, axi_awburst, axi_arsize, axi_arburst};
  assign axi_wlast = axi_wready && w_cnt == w_len;
  always_ff @(posedge ddr_clk or negedge rst)
    if (!rst) begin
      init_cnt <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      init_cnt <= init_cnt + 1'b1;
      init_done <= init_cnt == INIT_W'(INIT_CYCLES - 1);
    end
  always_ff @(posedge ddr_clk or negedge rst)
    if (!rst) begin
      w_state <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_bid <= '0;
      w_idx <= '0;
      w_id <= '0;
      w_len <= '0;
      w_cnt <= '0;
    end else begin
      case (w_state)
        W_IDLE:
          if (axi_awready && axi_awvalid) begin
            w_idx <= axi_awaddr[IDX_W+BEAT_SHIFT-1:BEAT_SHIFT];
            w_id <= axi_awid;
            w_len <= axi_awlen;
            w_cnt <= '0;
            axi_awready <= 1'b0;
            axi_wready <= 1'b1;
            w_state <= W_DATA;
          end else axi_awready <= init_done;
        W_DATA:
          if (axi_wvalid) begin
            w_idx <= w_idx + 1'b1;
            if (w_cnt == w_len) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bid <= w_id;
              w_state <= W_RESP;
            end else w_cnt <= w_cnt + 1'b1;
          end
        W_RESP:
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            axi_bid <= '0;
            axi_awready <= init_done;
            w_state <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
    end
  always_ff @(posedge ddr_clk or negedge rst)
    if (!rst) begin
      r_state <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid <= 1'b0;
      axi_rlast <= 1'b0;
      axi_rid <= '0;
      r_idx <= '0;
      r_id <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE:
          if (axi_arready && axi_arvalid) begin
            r_idx <= axi_araddr[IDX_W+BEAT_SHIFT-1:BEAT_SHIFT];
            r_id <= axi_arid;
            r_len <= axi_arlen;
            r_cnt <= '0;
            axi_arready <= 1'b0;
            r_state <= R_FETCH;
          end else axi_arready <= init_done;
        R_FETCH: begin
          axi_rvalid <= 1'b1;
          axi_rid <= r_id;
          axi_rlast <= r_cnt == r_len;
          r_state <= R_DATA;
        end
        R_DATA:
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            axi_rlast <= 1'b0;
            axi_rid <= '0;
            if (axi_rlast) begin
              axi_arready <= init_done;
              r_state <= R_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_idx <= r_idx + 1'b1;
              r_state <= R_FETCH;
            end
          end
        default: r_state <= R_IDLE;
      endcase
    end
  ddr_axi_resp_mem #(.DEPTH_LOG2(MEM_DEPTH_LOG2), .BYTES(MEM_DQ_WIDTH)) u_mem (
    .clk(ddr_clk),
    .rst(rst),
    .we(axi_wready && axi_wvalid),
    .waddr(w_idx),
    .wdata(axi_wdata),
    .wstrb(axi_wstrb),
    .re(r_state == R_FETCH),
    .raddr(r_idx),
    .rdata(axi_rdata)
  );
endmodule

// File: tb/tb_ddr_axi_responder.sv
// tb_ddr_axi_responder: directed and randomized bursts checked against a byte-level storage model
module tb_ddr_axi_responder;
  localparam int AW = 28;
  localparam int BW = 256;
  localparam int SW = 32;
  localparam int DEPTH = 1024;
  logic          ddr_clk, rst;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [3:0]    axi_awid, axi_awlen, axi_arid, axi_arlen, axi_bid, axi_rid;
  logic [2:0]    axi_awsize, axi_arsize;
  logic [1:0]    axi_awburst, axi_arburst;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic          axi_rvalid, axi_rlast, axi_rready, init_done;
  logic [BW-1:0] axi_wdata, axi_rdata;
  logic [SW-1:0] axi_wstrb;
  logic [BW-1:0] model [DEPTH];
  logic [BW-1:0] wbeat [16];
  logic [SW-1:0] wstrbs [16];
  int checks, passed, failed, bhs, bv_cycles;

  ddr_axi_responder dut (
    .ddr_clk(ddr_clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wlast(axi_wlast), .axi_bid(axi_bid), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .axi_rready(axi_rready), .init_done(init_done)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  always @(posedge ddr_clk) begin
    if (axi_bvalid) bv_cycles++;
    if (axi_bvalid && axi_bready) bhs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] want);
    checks++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input int beat, input logic [BW-1:0] d, input logic [SW-1:0] s);
    int idx;
    idx = (int'(addr >> 3) + beat) % DEPTH;
    for (int b = 0; b < SW; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic aw_handshake(input logic [AW-1:0] addr, input logic [3:0] id, input logic [3:0] len);
    int n;
    axi_awaddr = addr; axi_awid = id; axi_awlen = len;
    axi_awsize = 3'($urandom); axi_awburst = 2'($urandom); axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < 64) begin tick(); n++; end
    check("aw_accept", n < 64, 1);
    tick();
    axi_awvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] id, input logic [3:0] len);
    int n, b0;
    aw_handshake(addr, id, len);
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(3) == 0) begin axi_wvalid = 1'b0; tick(); end
      axi_wvalid = 1'b1; axi_wdata = wbeat[i]; axi_wstrb = wstrbs[i];
      n = 0;
      while (!axi_wready && n < 64) begin tick(); n++; end
      check("wready", axi_wready, 1);
      check("wlast", axi_wlast, i == int'(len));
      model_write(addr, i, wbeat[i], wstrbs[i]);
      tick();
    end
    axi_wvalid = 1'b0;
    check("bvalid", axi_bvalid, 1);
    check("bid", axi_bid, id);
    repeat ($urandom_range(2)) begin tick(); check("bvalid_hold", axi_bvalid, 1); end
    b0 = bhs;
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check("b_once", bhs - b0, 1);
    tick();
    check("bvalid_clear", axi_bvalid, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] id, input logic [3:0] len, input int mode);
    logic [BW-1:0] want [16];
    int got, n;
    for (int i = 0; i < 16; i++) want[i] = model[(int'(addr >> 3) + i) % DEPTH];
    axi_araddr = addr; axi_arid = id; axi_arlen = len;
    axi_arsize = 3'($urandom); axi_arburst = 2'($urandom); axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < 64) begin tick(); n++; end
    check("ar_accept", n < 64, 1);
    tick();
    axi_arvalid = 1'b0;
    got = 0; n = 0;
    while (got <= int'(len) && n < 200) begin
      axi_rready = (mode == 1) ? (n % 2 == 0) : (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
      if (axi_rvalid) begin
        check("rdata", axi_rdata, want[got]);
        check("rid", axi_rid, id);
        check("rlast", axi_rlast, got == int'(len));
        if (axi_rready) got++;
      end
      tick();
      n++;
    end
    axi_rready = 1'b0;
    check("r_beats", got, int'(len) + 1);
    tick();
    check("r_done", axi_rvalid, 0);
    tick();
    check("r_no_extra", axi_rvalid, 0);
  endtask

  task automatic fill(input logic [3:0] len, input logic full);
    for (int i = 0; i < 16; i++) begin
      wbeat[i] = rnd_beat();
      wstrbs[i] = full ? '1 : SW'($urandom);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [3:0] l;
    int v0;
    rst = 1'b0;
    axi_awaddr = '0; axi_awid = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;
    axi_araddr = '0; axi_arid = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0; axi_arvalid = 1'b0;
    axi_rready = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", {axi_awready, axi_wready, axi_wlast, axi_bvalid, axi_bid, axi_arready,
                       axi_rvalid, axi_rlast, axi_rid, init_done}, 0);
    check("rst_rdata", axi_rdata, 0);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("init_done", init_done, k == 4);
      check("awready_init", axi_awready, 0);
      check("arready_init", axi_arready, 0);
    end
    tick();
    check("awready_up", axi_awready, 1);
    check("arready_up", axi_arready, 1);

    for (int i = 0; i < 16; i++) begin wbeat[i] = {32{8'(8'hA0 + i)}}; wstrbs[i] = '1; end
    do_write(28'h40, 4'h5, 4'd3);
    do_read(28'h40, 4'h9, 4'd3, 0);
    do_read(28'h40, 4'h2, 4'd3, 1);

    wbeat[0] = '1; wstrbs[0] = '1;
    do_write(28'h100, 4'h1, 4'd0);
    wbeat[0] = rnd_beat(); wstrbs[0] = 32'h0000000F;
    do_write(28'h100, 4'h3, 4'd0);
    do_read(28'h100, 4'h4, 4'd0, 0);

    fill(4'd1, 1'b1);
    do_write(28'((DEPTH - 1) << 3), 4'hA, 4'd1);
    do_read(28'h0, 4'hB, 4'd0, 0);
    do_read(28'((DEPTH - 1) << 3), 4'hC, 4'd1, 2);

    fill(4'd7, 1'b1);
    fork
      do_write(28'h3000, 4'hD, 4'd7);
      do_read(28'h40, 4'hE, 4'd3, 2);
    join
    do_read(28'h3000, 4'hF, 4'd7, 0);

    aw_handshake(28'h800, 4'h7, 4'd15);
    for (int i = 0; i < 2; i++) begin
      axi_wvalid = 1'b1; axi_wdata = rnd_beat(); axi_wstrb = '1;
      model_write(28'h800, i, axi_wdata, axi_wstrb);
      tick();
    end
    axi_wdata = rnd_beat();
    #2 rst = 1'b0;
    #1;
    check("abort_wready", axi_wready, 0);
    check("abort_bvalid", axi_bvalid, 0);
    check("abort_init", init_done, 0);
    axi_wvalid = 1'b0;
    v0 = bv_cycles;
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("abort_no_bresp", bv_cycles - v0, 0);
    fill(4'd3, 1'b1);
    do_write(28'hA00, 4'h6, 4'd3);
    do_read(28'hA00, 4'h8, 4'd3, 0);
    do_read(28'h800, 4'h1, 4'd1, 0);

    for (int t = 0; t < 8; t++) begin
      a = 28'($urandom_range(DEPTH - 1) << 3);
      l = 4'($urandom_range(15));
      fill(l, 1'b1);
      do_write(a, 4'($urandom), l);
      fill(l, 1'b0);
      do_write(a, 4'($urandom), l);
      do_read(a, 4'($urandom), l, 2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ddr_axi_responder.md
DDR_AXI_RESPONDER -- requirements
Module: ddr_axi_responder

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- MEM_ROW_WIDTH, 15, DDR row bits.
- MEM_BANK_WIDTH, 3, bank bits.
- MEM_COLUMN_WIDTH, 10, column bits.
- CTRL_ADDR_WIDTH, sum of the three above, AXI address width.
- MEM_DQ_WIDTH, 32, DQ width; beat = MEM_DQ_WIDTH*8 bits.
- MEM_DEPTH_LOG2, 10, log2 of the stored beat count.
REQ-002 Ports (name, direction, width, meaning) SHALL be, with clock and reset first:
- ddr_clk, in, 1, single clock. rst, in, 1, asynchronous active-low reset.
- axi_awaddr, in, CTRL_ADDR_WIDTH. axi_awid, in, 4. axi_awlen, in, 4. axi_awsize, in, 3. axi_awburst, in, 2. axi_awvalid, in, 1. axi_awready, out, 1.
- axi_wdata, in, MEM_DQ_WIDTH*8. axi_wstrb, in, MEM_DQ_WIDTH. axi_wvalid, in, 1. axi_wready, out, 1. axi_wlast, out, 1 (responder-driven, matching the write masters).
- axi_bid, out, 4. axi_bvalid, out, 1. axi_bready, in, 1.
- axi_araddr, in, CTRL_ADDR_WIDTH. axi_arid, in, 4. axi_arlen, in, 4. axi_arsize, in, 3. axi_arburst, in, 2. axi_arvalid, in, 1. axi_arready, out, 1.
- axi_rdata, out, MEM_DQ_WIDTH*8. axi_rvalid, out, 1. axi_rlast, out, 1. axi_rid, out, 4. axi_rready, in, 1.
- init_done, out, 1, storage ready.

Function
REQ-003 The block SHALL be the responder end of the frame-buffer AXI masters: on-chip storage of 2^MEM_DEPTH_LOG2 beats standing in for the DDR controller.
REQ-004 Beat index SHALL be address bits [MEM_DEPTH_LOG2+2:3]; each beat advances the address by 8; the index wraps modulo depth.
REQ-005 awsize, arsize, awburst and arburst SHALL be ignored; every burst SHALL be INCR with len+1 beats (1..16).
REQ-006 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- W_IDLE: awready=1. On awvalid, latch addr, id and len, clear the beat counter, go to W_DATA.
- W_DATA: wready=1. Each beat with wvalid=1 writes the bytes whose wstrb bit is 1 and increments the counter.
- wlast SHALL be 1 in the cycle of the beat where counter==len; that beat moves the FSM to W_RESP.
- W_RESP: bvalid=1, bid=latched id. Hold until bready=1, then go to W_IDLE.
REQ-007 The read FSM SHALL have states R_IDLE, R_FETCH and R_DATA.
- R_IDLE: arready=1. On arvalid, latch addr, id and len, go to R_FETCH.
- R_FETCH: one cycle of storage read latency, then go to R_DATA.
- R_DATA: rvalid=1, rid=latched id, rlast=1 on beat counter==len.
- rdata SHALL stay stable while rready=0.
- On rready=1: if not last, advance and go to R_FETCH; if last, go to R_IDLE.
REQ-008 Read and write FSMs SHALL run independently and concurrently.
REQ-009 A read and a write to the same index in the same cycle SHALL return the old data.
REQ-010 The first burst-accepting cycle SHALL be the cycle after init_done rises; awready and arready SHALL be 0 while init_done=0.
REQ-011 init_done SHALL rise 4 cycles after rst deasserts and then stay 1.

Reset
REQ-012 While rst=0, every output SHALL be 0, both FSMs SHALL be in their IDLE states, and the counters SHALL be 0.
REQ-013 Storage contents SHALL NOT be reset.
REQ-014 Reset asserted mid-burst SHALL abort the burst with no response.

Structure
REQ-015 FSM state encodings and the beat-to-index shift (3) SHALL live in a shared package, ddr_axi_pkg.
REQ-016 Storage SHALL be one sub-module, ddr_axi_resp_mem: simple dual-port, one write port with byte enables, one registered read port.

Verification
REQ-017 The bench SHALL cover:
- Reset release: init_done=1 at cycle 4; before that, awready=arready=0.
- Write awaddr=0x40, len=3, data A0..A3; then read araddr=0x40, len=3 -> rdata A0..A3, rlast only on beat 4, bvalid once with bid=awid.
- Backpressure: rready toggled 1/0 per cycle -> rdata held while rready=0, no beat lost or duplicated.
- wstrb=0x0000000F on an address previously holding all-ones -> read returns only the low 4 bytes updated.
- Wrap: awaddr=(2^MEM_DEPTH_LOG2-1)<<3, len=1 -> second beat lands at index 0.
- rst pulsed low during beat 2 of a 16-beat write -> bvalid never asserted; the next burst completes normally.
